i2c_master_writer: RTL and testbench
====================================

Name: i2c_master_writer

Overview:
- I2C bus master that performs single write transactions (7-bit address, R/W=0, then 0–4 data bytes) and generates a STOP.
- Drives the bus consumed by the team's I2C slave register block, whose device address is 7'h55 and which fills four byte registers in order.
- Sits between a control FSM (e.g. a button/UART command decoder) and the board SCL/SDA pins.
- SCL is push-pull. SDA is open-drain: the block drives 0 or releases to Z, and an external pull-up is required.

Parameters:
CLK_DIV, 250, system clocks per quarter SCL period (100 MHz / (4*250) = 100 kHz); legal range >= 4
MAX_BYTES, 4, maximum data bytes per transaction; num_bytes is clamped to this value

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request; accepted only when busy=0
addr  input  7  target device address, latched on start
num_bytes  input  3  data byte count 0..4, latched on start; values >4 are clamped to 4
wdata  input  32  payload latched on start; wdata[7:0] is sent first, then [15:8], [23:16], [31:24]
SCL  output  1  bus clock
SDA  inout  1  open-drain data line
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when STOP completes
ack_err  output  1  set on any NACK; held until the next accepted start

Behaviour:
- Reset (synchronous, active-high) produces:
  - SCL=1, SDA released, busy=0, done=0, ack_err=0.
  - Quarter counter and bit counter = 0, state=IDLE.
  - If asserted mid-transaction, the bus is released on the next edge and no STOP sequence is generated.
- Timebase:
  - A quarter counter counts 0..CLK_DIV-1.
  - Each state step occurs when the counter wraps.
  - The counter is held at 0 in IDLE.
- SDA input path: a 2-flop synchronizer (reset value 1). The ACK bit is sampled from the synchronized value on the last clk of quarter Q2.
- IDLE:
  - Outputs: SCL=1, SDA released, busy=0.
  - On start: latch addr, num_bytes, wdata; form shift byte {addr,1'b0}; clear ack_err; go to START.
- START (2 quarters):
  - Quarter 1: SCL=1, SDA=0.
  - Quarter 2: SCL=1, SDA=0.
  - Then go to ADDR.
- ADDR and DATA (8 bits each, MSB first). Each bit takes 4 quarters:
  - Q0: SCL=0, SDA is set to the bit value (0 is driven, 1 releases the line).
  - Q1: SCL=0.
  - Q2: SCL=1.
  - Q3: SCL=1.
  - SDA changes only while SCL=0.
- ACK bit (after every byte):
  - 4 quarters with the same SCL pattern and SDA released.
  - Sampled 0 means ACK; 1 means NACK.
- Sequencing after an ACK bit:
  - NACK: set ack_err and go to STOP.
  - ACK with bytes remaining: load the next byte and go to DATA.
  - ACK with no bytes remaining: go to STOP.
  - num_bytes=0 is an address-only probe.
- STOP (3 quarters):
  - Quarter 1: SCL=0, SDA=0.
  - Quarter 2: SCL=1, SDA=0.
  - Quarter 3: SCL=1, SDA released (rising SDA while SCL high).
  - Then IDLE, with done=1 for one cycle; busy=0 in that same cycle.
- Transaction length: total quarters = 2 + 36*(1+N) + 3 for a fully ACKed transaction of N bytes. clk cycles = quarters * CLK_DIV.
- Simultaneous events:
  - start while busy=1 is ignored; latched values are unchanged.
  - start in the done cycle is accepted.
- ack_err stays 0 on a fully ACKed transaction.

Test Plan:
- CLK_DIV=4, addr=7'h55, num_bytes=4, wdata=32'hDDCCBBAA, slave model attached:
  - slave regs 0..3 = AA, BB, CC, DD.
  - ack_err=0.
  - done pulses exactly 740 clk after start.
- addr=7'h20 with no responder (pull-up only):
  - NACK on the address byte, ack_err=1.
  - STOP follows the 9th SCL pulse, no data bits are sent.
  - done pulses after (2+36+3)*4=164 clk.
- num_bytes=1, wdata[7:0]=8'h3C to the slave:
  - only slave reg0=3C.
  - STOP is observed as SDA rising while SCL=1.
  - busy duration = 308 clk.
- Start handling:
  - start pulsed while busy (mid byte 2) -> ignored; the transaction completes with the original wdata.
  - start asserted in the done cycle -> a second transaction begins.
- reset asserted during bit 5 of data byte 1 -> next cycle SCL=1, SDA=Z, busy=0, ack_err=0; a subsequent start runs a clean transaction.
- Bus-protocol checker over all runs: SDA never changes while SCL=1 except at START and STOP; SCL high and low phases are each 2*CLK_DIV clk.

Source files
------------

// File: rtl/i2c_master_writer_if.sv
// i2c_master_writer_if: request/status handshake between a command source and the I2C write master.
interface i2c_master_writer_if;
    logic        start;
    logic [6:0]  addr;
    logic [2:0]  num_bytes;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        ack_err;
    modport master (output start, addr, num_bytes, wdata, input busy, done, ack_err);
    modport slave  (input start, addr, num_bytes, wdata, output busy, done, ack_err);
endinterface

// File: rtl/i2c_master_writer.sv
// i2c_master_writer: single-transaction I2C write master (7-bit address, 0..MAX_BYTES data bytes, STOP).
module i2c_master_writer #(
    parameter int CLK_DIV   = 250,
    parameter int MAX_BYTES = 4
) (
    input  logic               clk,
    input  logic               reset,
    i2c_master_writer_if.slave ctl,
    output logic               SCL,
    inout  wire                SDA
);
    localparam int QW = $clog2(CLK_DIV);
    typedef enum logic [2:0] {IDLE, START, ADDR, DATA, ACK, STOP} state_t;
    state_t        state;
    logic [QW-1:0] qcnt;
    logic [1:0]    ph;
    logic [2:0]    bcnt, left;
    logic [7:0]    shift;
    logic [31:0]   data;
    logic [1:0]    sda_sync;
    logic          sda_low, ack_bit, step;
    assign step = qcnt == QW'(CLK_DIV - 1);
    assign SDA  = sda_low ? 1'b0 : 1'bz;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            qcnt        <= '0;
            ph          <= '0;
            bcnt        <= '0;
            left        <= '0;
            shift       <= '0;
            data        <= '0;
            sda_sync    <= 2'b11;
            sda_low     <= 1'b0;
            ack_bit     <= 1'b0;
            SCL         <= 1'b1;
            ctl.busy    <= 1'b0;
            ctl.done    <= 1'b0;
            ctl.ack_err <= 1'b0;
        end else begin
            sda_sync <= {sda_sync[0], SDA};
            ctl.done <= 1'b0;
            qcnt     <= (state == IDLE || step) ? '0 : qcnt + 1'b1;
            if (state == IDLE) begin
                if (ctl.start) begin
                    state       <= START;
                    ph          <= '0;
                    bcnt        <= '0;
                    shift       <= {ctl.addr, 1'b0};
                    data        <= ctl.wdata;
                    left        <= (ctl.num_bytes > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : ctl.num_bytes;
                    sda_low     <= 1'b1;
                    SCL         <= 1'b1;
                    ctl.busy    <= 1'b1;
                    ctl.ack_err <= 1'b0;
                end
            end else if (step) begin
                ph <= ph + 1'b1;
                case (state)
                    START: if (ph == 2'd1) begin
                        state   <= ADDR;
                        ph      <= '0;
                        SCL     <= 1'b0;
                        sda_low <= ~shift[7];
                    end
                    ADDR, DATA: begin
                        // SCL is high in quarters 2 and 3 of every bit
                        SCL <= ph == 2'd1 || ph == 2'd2;
                        if (ph == 2'd3) begin
                            bcnt <= bcnt + 1'b1;
                            if (bcnt == 3'd7) begin
                                state   <= ACK;
                                sda_low <= 1'b0;
                            end else begin
                                shift   <= {shift[6:0], 1'b0};
                                sda_low <= ~shift[6];
                            end
                        end
                    end
                    ACK: begin
                        SCL <= ph == 2'd1 || ph == 2'd2;
                        if (ph == 2'd2) ack_bit <= sda_sync[1];
                        if (ph == 2'd3) begin
                            if (ack_bit || left == 3'd0) begin
                                state       <= STOP;
                                sda_low     <= 1'b1;
                                ctl.ack_err <= ack_bit;
                            end else begin
                                state   <= DATA;
                                shift   <= data[7:0];
                                data    <= data >> 8;
                                left    <= left - 1'b1;
                                sda_low <= ~data[7];
                            end
                        end
                    end
                    STOP: begin
                        SCL <= 1'b1;
                        if (ph == 2'd1) sda_low <= 1'b0;
                        if (ph == 2'd2) begin
                            state    <= IDLE;
                            ph       <= '0;
                            ctl.busy <= 1'b0;
                            ctl.done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_writer.sv
// tb_i2c_master_writer: directed tests of the I2C write master against a behavioural slave at 7'h55.
module tb_i2c_master_writer;
    localparam int D = 4;
    logic clk = 1'b0, reset = 1'b1;
    logic SCL;
    wire  SDA;
    logic s_drv = 1'b0;
    i2c_master_writer_if ctl();
    i2c_master_writer #(.CLK_DIV(D), .MAX_BYTES(4)) dut (.clk(clk), .reset(reset), .ctl(ctl), .SCL(SCL), .SDA(SDA));
    always #5 clk = ~clk;
    pullup (SDA);
    assign SDA = s_drv ? 1'b0 : 1'bz;

    int checks = 0, passes = 0;
    int starts, stops, rises, phase_bad, run, low_len, ptr, s_bit;
    logic mon_clr = 1'b0, slave_clr = 1'b0;
    logic p_scl = 1'b1, p_sda = 1'b1, low_ok, st, sp, rise, fall, s_act, s_addr, s_ok;
    logic [7:0] s_sh;
    logic [7:0] sregs [4];

    // bus monitor and slave model share one sampled view of SCL/SDA
    always @(negedge clk) begin
        st   = p_scl && SCL && p_sda && !SDA;
        sp   = p_scl && SCL && !p_sda && SDA;
        rise = !p_scl && SCL;
        fall = p_scl && !SCL;
        if (mon_clr) begin
            starts = 0; stops = 0; rises = 0; phase_bad = 0; run = 1; low_len = 0; low_ok = 1'b0;
        end else begin
            if (st) starts++;
            if (sp) begin stops++; low_ok = 1'b0; end
            if (rise) rises++;
            if (SCL !== p_scl) begin
                if (fall) begin
                    if (low_ok && (run != 2 * D || low_len != 2 * D)) phase_bad++;
                    low_ok = 1'b0;
                end else begin
                    low_len = run; low_ok = 1'b1;
                end
                run = 1;
            end else run++;
        end
        if (slave_clr) begin
            for (int i = 0; i < 4; i++) sregs[i] = 8'h00;
            s_act = 1'b0; s_drv = 1'b0; ptr = 0; s_bit = 0; s_ok = 1'b0; s_addr = 1'b0;
        end else if (st) begin
            s_act = 1'b1; s_bit = 0; s_addr = 1'b1; s_drv = 1'b0; ptr = 0;
        end else if (sp) begin
            s_act = 1'b0; s_drv = 1'b0;
        end else if (s_act && rise && s_bit < 8) begin
            s_sh = {s_sh[6:0], SDA}; s_bit++;
        end else if (s_act && fall && s_bit == 8) begin
            if (s_addr) s_ok = s_sh == {7'h55, 1'b0};
            else if (s_ok && ptr < 4) begin sregs[ptr] = s_sh; ptr++; end
            s_drv = s_ok; s_addr = 1'b0; s_bit = 9;
        end else if (s_act && fall && s_bit == 9) begin
            s_drv = 1'b0; s_bit = 0;
        end
        p_scl = SCL;
        p_sda = SDA;
    end

    task automatic clear_bench;
        mon_clr = 1'b1; slave_clr = 1'b1;
        repeat (2) @(negedge clk);
        mon_clr = 1'b0; slave_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [6:0] a, input logic [2:0] n, input logic [31:0] w);
        @(negedge clk);
        ctl.start = 1'b1; ctl.addr = a; ctl.num_bytes = n; ctl.wdata = w;
        @(negedge clk);
        ctl.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc = 0; busy_cyc = 0;
        while (ctl.done !== 1'b1 && cyc < 5000) begin
            if (ctl.busy === 1'b1) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; ctl.start = 1'b0; ctl.addr = '0; ctl.num_bytes = '0; ctl.wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (SCL !== 1'b1) $display("FAIL reset_scl got %b want 1", SCL); else passes++;
        checks++; if (SDA !== 1'b1) $display("FAIL reset_sda got %b want 1", SDA); else passes++;
        checks++; if (ctl.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", ctl.busy); else passes++;
        checks++; if (ctl.done !== 1'b0) $display("FAIL reset_done got %b want 0", ctl.done); else passes++;
        checks++; if (ctl.ack_err !== 1'b0) $display("FAIL reset_ack_err got %b want 0", ctl.ack_err); else passes++;
        reset = 1'b0;
        clear_bench;
    endtask

    task automatic test_full_write;
        int cyc, bc;
        clear_bench;
        pulse_start(7'h55, 3'd4, 32'hDDCCBBAA);
        wait_done(cyc, bc);
        checks++; if (cyc != 740) $display("FAIL full_done_latency got %0d want 740", cyc); else passes++;
        checks++; if (bc != 740) $display("FAIL full_busy_len got %0d want 740", bc); else passes++;
        checks++; if (ctl.ack_err !== 1'b0) $display("FAIL full_ack_err got %b want 0", ctl.ack_err); else passes++;
        checks++; if ({sregs[3], sregs[2], sregs[1], sregs[0]} !== 32'hDDCCBBAA)
            $display("FAIL full_regs got %h%h%h%h want ddccbbaa", sregs[3], sregs[2], sregs[1], sregs[0]); else passes++;
        checks++; if (starts != 1 || stops != 1) $display("FAIL full_start_stop got %0d/%0d want 1/1", starts, stops); else passes++;
        checks++; if (rises != 46) $display("FAIL full_scl_pulses got %0d want 46", rises); else passes++;
        checks++; if (phase_bad != 0) $display("FAIL full_scl_phase got %0d bad want 0", phase_bad); else passes++;
        @(negedge clk);
        checks++; if (ctl.done !== 1'b0) $display("FAIL full_done_pulse got %b want 0", ctl.done); else passes++;
    endtask

    task automatic test_nack;
        int cyc, bc;
        clear_bench;
        pulse_start(7'h20, 3'd4, 32'h12345678);
        wait_done(cyc, bc);
        checks++; if (cyc != 164) $display("FAIL nack_done_latency got %0d want 164", cyc); else passes++;
        checks++; if (ctl.ack_err !== 1'b1) $display("FAIL nack_ack_err got %b want 1", ctl.ack_err); else passes++;
        checks++; if (rises != 10) $display("FAIL nack_scl_pulses got %0d want 10", rises); else passes++;
        checks++; if (stops != 1) $display("FAIL nack_stop got %0d want 1", stops); else passes++;
        checks++; if (phase_bad != 0) $display("FAIL nack_scl_phase got %0d bad want 0", phase_bad); else passes++;
        repeat (10) @(negedge clk);
        checks++; if (ctl.ack_err !== 1'b1) $display("FAIL nack_ack_err_hold got %b want 1", ctl.ack_err); else passes++;
    endtask

    task automatic test_single_byte;
        int cyc, bc;
        clear_bench;
        pulse_start(7'h55, 3'd1, 32'h1122333C);
        checks++; if (ctl.ack_err !== 1'b0) $display("FAIL single_ack_err_clear got %b want 0", ctl.ack_err); else passes++;
        checks++; if (ctl.busy !== 1'b1) $display("FAIL single_busy got %b want 1", ctl.busy); else passes++;
        wait_done(cyc, bc);
        checks++; if (bc != 308) $display("FAIL single_busy_len got %0d want 308", bc); else passes++;
        checks++; if (sregs[0] !== 8'h3C) $display("FAIL single_reg0 got %h want 3c", sregs[0]); else passes++;
        checks++; if (sregs[1] !== 8'h00) $display("FAIL single_reg1 got %h want 00", sregs[1]); else passes++;
        checks++; if (stops != 1) $display("FAIL single_stop got %0d want 1", stops); else passes++;
        checks++; if (SCL !== 1'b1 || SDA !== 1'b1) $display("FAIL single_idle_bus got %b%b want 11", SCL, SDA); else passes++;
    endtask

    task automatic test_clamp;
        int cyc, bc;
        clear_bench;
        pulse_start(7'h55, 3'd7, 32'h87654321);
        wait_done(cyc, bc);
        checks++; if (cyc != 740) $display("FAIL clamp_latency got %0d want 740", cyc); else passes++;
        checks++; if (sregs[0] !== 8'h21 || sregs[3] !== 8'h87)
            $display("FAIL clamp_regs got %h..%h want 21..87", sregs[0], sregs[3]); else passes++;
    endtask

    task automatic test_busy_ignore;
        int cyc, bc;
        clear_bench;
        pulse_start(7'h55, 3'd4, 32'h44332211);
        repeat (368) @(negedge clk);
        checks++; if (ctl.busy !== 1'b1) $display("FAIL ignore_busy got %b want 1", ctl.busy); else passes++;
        pulse_start(7'h20, 3'd1, 32'hFFFFFFFF);
        wait_done(cyc, bc);
        checks++; if (cyc != 370) $display("FAIL ignore_latency got %0d want 370", cyc); else passes++;
        checks++; if ({sregs[3], sregs[2], sregs[1], sregs[0]} !== 32'h44332211)
            $display("FAIL ignore_regs got %h%h%h%h want 44332211", sregs[3], sregs[2], sregs[1], sregs[0]); else passes++;
        checks++; if (starts != 1 || ctl.ack_err !== 1'b0)
            $display("FAIL ignore_single_txn got starts=%0d ack_err=%b want 1/0", starts, ctl.ack_err); else passes++;
    endtask

    task automatic test_back_to_back;
        int cyc, bc;
        clear_bench;
        pulse_start(7'h55, 3'd2, 32'h0000BEEF);
        wait_done(cyc, bc);
        checks++; if (cyc != 452) $display("FAIL b2b_first_latency got %0d want 452", cyc); else passes++;
        ctl.start = 1'b1; ctl.addr = 7'h55; ctl.num_bytes = 3'd1; ctl.wdata = 32'h0000005A;
        @(negedge clk);
        ctl.start = 1'b0;
        checks++; if (ctl.busy !== 1'b1) $display("FAIL b2b_accept got %b want 1", ctl.busy); else passes++;
        wait_done(cyc, bc);
        checks++; if (cyc != 308) $display("FAIL b2b_second_latency got %0d want 308", cyc); else passes++;
        checks++; if (sregs[0] !== 8'h5A || sregs[1] !== 8'hBE)
            $display("FAIL b2b_regs got %h %h want 5a be", sregs[0], sregs[1]); else passes++;
        checks++; if (starts != 2 || stops != 2 || phase_bad != 0)
            $display("FAIL b2b_protocol got %0d/%0d/%0d want 2/2/0", starts, stops, phase_bad); else passes++;
    endtask

    task automatic test_mid_reset;
        int cyc, bc;
        clear_bench;
        pulse_start(7'h55, 3'd4, 32'hFFFFFF00);
        repeat (240) @(negedge clk);
        checks++; if (SCL !== 1'b1 || SDA !== 1'b0) $display("FAIL midrst_pre_bus got %b%b want 10", SCL, SDA); else passes++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (SCL !== 1'b1 || SDA !== 1'b1) $display("FAIL midrst_bus got %b%b want 11", SCL, SDA); else passes++;
        checks++; if (ctl.busy !== 1'b0 || ctl.ack_err !== 1'b0 || ctl.done !== 1'b0)
            $display("FAIL midrst_status got %b%b%b want 000", ctl.busy, ctl.ack_err, ctl.done); else passes++;
        repeat (20) @(negedge clk);
        checks++; if (SCL !== 1'b1 || SDA !== 1'b1 || ctl.done !== 1'b0)
            $display("FAIL midrst_quiet got %b%b%b want 110", SCL, SDA, ctl.done); else passes++;
        clear_bench;
        pulse_start(7'h55, 3'd2, 32'h0000A55A);
        wait_done(cyc, bc);
        checks++; if (cyc != 452) $display("FAIL midrst_latency got %0d want 452", cyc); else passes++;
        checks++; if (sregs[0] !== 8'h5A || sregs[1] !== 8'hA5 || ctl.ack_err !== 1'b0)
            $display("FAIL midrst_regs got %h %h err=%b want 5a a5 0", sregs[0], sregs[1], ctl.ack_err); else passes++;
        checks++; if (starts != 1 || stops != 1 || phase_bad != 0)
            $display("FAIL midrst_protocol got %0d/%0d/%0d want 1/1/0", starts, stops, phase_bad); else passes++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_full_write;
        test_nack;
        test_single_byte;
        test_clamp;
        test_busy_ignore;
        test_back_to_back;
        test_mid_reset;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
